wb_arbiter: RTL
===============

Name: wb_arbiter

Overview:
- Two-master Wishbone arbiter that shares the single master port of the SRAM/UART/TRNG/SPI interconnect.
- M0 is the Caravel management Wishbone port; M1 is a secondary on-chip master (DMA / key-loader).
- Round-robin grant, held for a whole bus cycle (cyc high). A watchdog converts a hung slave access into a single-cycle bus error. The interconnect slaves never drive err, so the watchdog is the only error source.

Parameters:
- TIMEOUT_CYCLES, 255, cycles stb may stay unacknowledged before a timeout err is raised (range 2..255).
- CNT_W, 8, width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk_i  in  1  system clock; all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- m0_wb_dat_i / m1_wb_dat_i  in  32  master write data.
- m0_wb_adr_i / m1_wb_adr_i  in  32  master byte address.
- m0_wb_sel_i / m1_wb_sel_i  in  4  byte selects.
- m0_wb_we_i / m1_wb_we_i  in  1  write enable.
- m0_wb_cyc_i / m1_wb_cyc_i  in  1  cycle request.
- m0_wb_stb_i / m1_wb_stb_i  in  1  strobe.
- m0_wb_dat_o / m1_wb_dat_o  out  32  read data.
- m0_wb_ack_o / m1_wb_ack_o  out  1  acknowledge.
- m0_wb_err_o / m1_wb_err_o  out  1  error (slave err OR timeout).
- s_wb_dat_o  out  32  to interconnect.
- s_wb_adr_o  out  32  to interconnect.
- s_wb_sel_o  out  4  to interconnect.
- s_wb_we_o  out  1  to interconnect.
- s_wb_cyc_o  out  1  to interconnect.
- s_wb_stb_o  out  1  to interconnect.
- s_wb_dat_i  in  32  from interconnect.
- s_wb_ack_i  in  1  from interconnect.
- s_wb_err_i  in  1  from interconnect.
- timeout_o  out  1  one-cycle pulse per watchdog timeout (status/IRQ).

Behaviour:
- Reset (rst_i=1, takes effect immediately, asynchronous):
  - state=IDLE, last_grant=1 (so M0 wins the first tie), counter=0.
  - All outputs 0.
  - Reset asserted mid-transfer abandons the transfer; no ack or err is issued.
- State machine: IDLE, OWN0, OWN1.
- IDLE:
  - All s_wb_* outputs are 0.
  - Next state: only m0 cyc -> OWN0; only m1 cyc -> OWN1.
  - Both cyc -> grant the master not equal to last_grant; last_grant updates to the new owner.
  - Neither cyc -> stay in IDLE.
- OWNx:
  - s_wb_{dat,adr,sel,we,cyc,stb}_o = master x inputs, combinational.
  - mx_wb_dat_o = s_wb_dat_i; mx_wb_ack_o = s_wb_ack_i; mx_wb_err_o = s_wb_err_i | timeout.
  - The non-owner gets dat/ack/err = 0.
  - mx cyc low -> IDLE next cycle, giving exactly one dead cycle between ownerships.
  - Owner keeps the bus across multiple stb beats while cyc stays high; no preemption.
- Arbitration latency: cyc rising in IDLE -> s_wb_cyc_o high on the following cycle.
- Watchdog (OWNx only):
  - Counter increments each cycle that owner stb=1 and s_wb_ack_i=0 and s_wb_err_i=0.
  - Cleared on ack, err, stb=0, or leaving OWNx.
  - When counter == TIMEOUT_CYCLES-1 and still no ack/err: timeout=1 combinationally that cycle.
  - Effects of timeout: owner err_o=1 and timeout_o=1 for exactly one cycle; counter clears.
  - Master must drop stb/cyc or retry; the watchdog restarts from 0 if stb stays high.
  - Ack in the timeout cycle wins: ack passes through, no err, no timeout_o.
- Late ack after a timeout is passed to the owner unchanged; masters tolerate or ignore it.
- Owner cyc dropping in the same cycle as an ack: ack is delivered, then IDLE.
- Both requesting while IDLE after an M1 ownership -> M0; after an M0 ownership -> M1.
- A master that drops cyc while waiting (not granted) loses nothing; there is no queued state.

Test Plan:
- Reset, then M0 read adr 0x0000_1004 with slave ack after 2 cycles, dat 0xA5A5_0001 -> s_wb_cyc_o high 1 cycle after m0 cyc; m0_wb_dat_o=0xA5A5_0001 with ack; m1 outputs all 0.
- M0 and M1 raise cyc in the same cycle, each doing one-beat transfers, repeated 4 times -> grant order M0, M1, M0, M1 with one idle cycle between each.
- M1 holds cyc for a 3-beat burst to 0x0000_0000/4/8 while M0 requests -> all 3 beats go to M1; M0 granted only after M1 cyc drops plus 1 cycle.
- TIMEOUT_CYCLES=16, slave never acks M0 -> m0_wb_err_o and timeout_o high exactly on the 16th stb cycle for one cycle; counter restarts if stb held.
- TIMEOUT_CYCLES=16, slave acks on the 16th cycle -> ack delivered, err=0, timeout_o=0.
- rst_i pulsed while OWN1 mid-access -> all outputs 0 immediately, state IDLE; next simultaneous request grants M0.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: two-master round-robin Wishbone arbiter with per-access watchdog timeout.
module wb_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] m0_wb_dat_i,
  input  logic [31:0] m0_wb_adr_i,
  input  logic [3:0]  m0_wb_sel_i,
  input  logic        m0_wb_we_i,
  input  logic        m0_wb_cyc_i,
  input  logic        m0_wb_stb_i,
  output logic [31:0] m0_wb_dat_o,
  output logic        m0_wb_ack_o,
  output logic        m0_wb_err_o,
  input  logic [31:0] m1_wb_dat_i,
  input  logic [31:0] m1_wb_adr_i,
  input  logic [3:0]  m1_wb_sel_i,
  input  logic        m1_wb_we_i,
  input  logic        m1_wb_cyc_i,
  input  logic        m1_wb_stb_i,
  output logic [31:0] m1_wb_dat_o,
  output logic        m1_wb_ack_o,
  output logic        m1_wb_err_o,
  output logic [31:0] s_wb_dat_o,
  output logic [31:0] s_wb_adr_o,
  output logic [3:0]  s_wb_sel_o,
  output logic        s_wb_we_o,
  output logic        s_wb_cyc_o,
  output logic        s_wb_stb_o,
  input  logic [31:0] s_wb_dat_i,
  input  logic        s_wb_ack_i,
  input  logic        s_wb_err_i,
  output logic        timeout_o
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;
  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              own0, own1, busy, timeout;
  always_comb begin
    own0    = state_q == OWN0;
    own1    = state_q == OWN1;
    busy    = (own0 ? m0_wb_stb_i : own1 ? m1_wb_stb_i : 1'b0) & ~s_wb_ack_i & ~s_wb_err_i;
    timeout = busy & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    cnt_d   = (busy & ~timeout) ? cnt_q + 1'b1 : '0;
    // on a tie the master that did not own the bus last wins
    state_d = own0 ? (m0_wb_cyc_i ? OWN0 : IDLE) :
              own1 ? (m1_wb_cyc_i ? OWN1 : IDLE) :
              (m0_wb_cyc_i & m1_wb_cyc_i) ? (last_q ? OWN0 : OWN1) :
              m0_wb_cyc_i ? OWN0 : m1_wb_cyc_i ? OWN1 : IDLE;
    last_d  = (state_q == IDLE && state_d != IDLE) ? (state_d == OWN1) : last_q;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  assign s_wb_dat_o  = own0 ? m0_wb_dat_i : own1 ? m1_wb_dat_i : '0;
  assign s_wb_adr_o  = own0 ? m0_wb_adr_i : own1 ? m1_wb_adr_i : '0;
  assign s_wb_sel_o  = own0 ? m0_wb_sel_i : own1 ? m1_wb_sel_i : '0;
  assign s_wb_we_o   = own0 ? m0_wb_we_i  : own1 & m1_wb_we_i;
  assign s_wb_cyc_o  = own0 ? m0_wb_cyc_i : own1 & m1_wb_cyc_i;
  assign s_wb_stb_o  = own0 ? m0_wb_stb_i : own1 & m1_wb_stb_i;
  assign m0_wb_dat_o = own0 ? s_wb_dat_i : '0;
  assign m1_wb_dat_o = own1 ? s_wb_dat_i : '0;
  assign m0_wb_ack_o = own0 & s_wb_ack_i;
  assign m1_wb_ack_o = own1 & s_wb_ack_i;
  assign m0_wb_err_o = own0 & (s_wb_err_i | timeout);
  assign m1_wb_err_o = own1 & (s_wb_err_i | timeout);
  assign timeout_o   = timeout;
endmodule
